ads8363_capture: RTL and testbench

// Digitises the serial analog stream of the AFE0064 sequencer through an ADS8363 SAR ADC.

---
 rtl/ads8363_capture_pkg.sv | 25 ++
 rtl/ads8363_capture_spi_rx.sv | 61 ++++++
 rtl/ads8363_capture.sv | 137 +++++++++++++
 tb/tb_ads8363_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ads8363_capture_pkg.sv
// Shared constants, AFE sequencer timing and FSM encoding for the ADS8363 capture path.
package ads8363_capture_pkg;

  localparam int NUM_CH     = 64;
  localparam int DATA_W     = 16;
  localparam int IDX_W      = $clog2(NUM_CH);

  // Analog settling and conversion timing tied to the AFE0064 sequencer, in clk cycles
  localparam int SETTLE_CYC = 20;
  localparam int CONV_CYC   = 40;
  localparam int SCLK_HALF  = 2;

  localparam int TMR_W  = $clog2((CONV_CYC > SETTLE_CYC) ? CONV_CYC : SETTLE_CYC);
  localparam int DIV_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONVST,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/ads8363_capture_spi_rx.sv
// SCLK divider and MSB-first shift register reading one ADS8363 result from SDOA.
module ads8363_spi_rx
  import ads8363_capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              sdoa,
  output logic              sclk,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data
);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_HALF - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

  logic [DIV_W-1:0]  div;
  logic [HALF_W-1:0] half;

  // SCLK idles high, so the first toggle is a fall; data is taken on each low-to-high toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      div  <= '0;
      half <= '0;
      data <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
        sclk <= 1'b1;
        div  <= '0;
        half <= '0;
      end else if (start) begin
        busy <= 1'b1;
        sclk <= 1'b1;
        div  <= '0;
        half <= '0;
      end else if (busy) begin
        if (div == DIV_LAST) begin
          div  <= '0;
          sclk <= ~sclk;
          half <= half + 1'b1;
          if (!sclk)
            data <= {data[DATA_W-2:0], sdoa};
          if (half == HALF_LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ads8363_capture.sv
// Captures one ADS8363 conversion per AFE_CLK rise and posts it with its channel index.
module ads8363_capture
  import ads8363_capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              afe_clk,
  input  logic              afe_rd_act,
  output logic              adc_convst,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  input  logic              adc_sdoa,
  output logic [DATA_W-1:0] pix_data,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              line_done,
  output logic              overrun
);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] CONV_LAST   = TMR_W'(CONV_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CH - 1);

  state_t              state;
  logic [TMR_W-1:0]    tmr;
  logic [IDX_W-1:0]    chan_cnt;
  logic                afe_clk_q;
  logic                rise;
  logic                result_ready;
  logic                spi_start;
  logic                spi_busy;
  logic                spi_done;
  logic [DATA_W-1:0]   spi_data;

  assign rise         = afe_clk & ~afe_clk_q;
  assign spi_start    = (state == CONVST) && (tmr == CONV_LAST) && afe_rd_act && !spi_busy;
  assign result_ready = (state == DONE) && afe_rd_act;
  assign line_done    = pix_valid && pix_ready && (pix_idx == LAST_IDX);

  ads8363_spi_rx u_spi_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (spi_start),
    .abort (!afe_rd_act),
    .sdoa  (adc_sdoa),
    .sclk  (adc_sclk),
    .busy  (spi_busy),
    .done  (spi_done),
    .data  (spi_data)
  );

  // Dropping afe_rd_act abandons any conversion in flight and parks the ADC lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmr        <= '0;
      adc_convst <= 1'b0;
      adc_cs_n   <= 1'b1;
      afe_clk_q  <= 1'b0;
    end else begin
      afe_clk_q <= afe_clk;
      if (!afe_rd_act) begin
        state      <= IDLE;
        tmr        <= '0;
        adc_convst <= 1'b0;
        adc_cs_n   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= SETTLE;
              tmr   <= '0;
            end
          end
          SETTLE: begin
            if (tmr == SETTLE_LAST) begin
              state      <= CONVST;
              tmr        <= '0;
              adc_convst <= 1'b1;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          CONVST: begin
            if (tmr == CONV_LAST) begin
              state      <= SHIFT;
              adc_convst <= 1'b0;
              adc_cs_n   <= 1'b0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          SHIFT: begin
            if (spi_done) begin
              state    <= DONE;
              adc_cs_n <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // The counter advances even for dropped results so indices stay tied to AFE channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      chan_cnt <= '0;
    else if (!afe_rd_act)
      chan_cnt <= '0;
    else if (result_ready)
      chan_cnt <= (chan_cnt == LAST_IDX) ? '0 : chan_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data  <= '0;
      pix_idx   <= '0;
      pix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (result_ready && (!pix_valid || pix_ready)) begin
        pix_data  <= spi_data;
        pix_idx   <= chan_cnt;
        pix_valid <= 1'b1;
      end else if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
      end
      if ((result_ready && pix_valid && !pix_ready) ||
          (rise && afe_rd_act && (state != IDLE)))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ads8363_capture.sv
// Directed self-checking bench for ads8363_capture with a behavioural ADS8363 SDOA model.
module tb_ads8363_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        afe_clk;
  logic        afe_rd_act;
  logic        adc_convst;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_sdoa;
  logic [15:0] pix_data;
  logic [5:0]  pix_idx;
  logic        pix_valid;
  logic        pix_ready;
  logic        line_done;
  logic        overrun;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] adc_word = 16'h0000;
  int          bit_cnt = 0;
  int          convst_cycles = 0;
  int          sclk_rises = 0;
  int          ld_count = 0;
  logic [5:0]  ld_idx = 6'd0;
  logic [21:0] hs_q[$];

  always #5 clk = ~clk;

  ads8363_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .afe_clk    (afe_clk),
    .afe_rd_act (afe_rd_act),
    .adc_convst (adc_convst),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_sdoa   (adc_sdoa),
    .pix_data   (pix_data),
    .pix_idx    (pix_idx),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .line_done  (line_done),
    .overrun    (overrun)
  );

  // ADC model: each SCLK fall while selected presents the next bit, MSB first
  initial adc_sdoa = 1'b0;
  always @(negedge adc_cs_n) bit_cnt = 0;
  always @(negedge adc_sclk) begin
    if (adc_cs_n == 1'b0 && bit_cnt < 16) begin
      adc_sdoa = adc_word[15 - bit_cnt];
      bit_cnt++;
    end
  end

  always @(posedge adc_sclk) if (adc_cs_n == 1'b0) sclk_rises++;

  always @(negedge clk) begin
    if (adc_convst === 1'b1) convst_cycles++;
    if (line_done === 1'b1) begin
      ld_count++;
      ld_idx = pix_idx;
    end
    if (rst_n === 1'b1 && pix_valid === 1'b1 && pix_ready === 1'b1)
      hs_q.push_back({pix_idx, pix_data});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One AFE_CLK pulse; the rise is seen on the first clk edge, returns 3 edges later
  task automatic applyStimulus(input logic [15:0] word);
    adc_word = word;
    afe_clk  = 1'b1;
    tick(4);
    afe_clk  = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (pix_valid !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(pix_valid), 32'd1);
  endtask

  task automatic handshake();
    pix_ready = 1'b1;
    tick(1);
    pix_ready = 1'b0;
  endtask

  task automatic lineRestart();
    afe_rd_act = 1'b0;
    tick(2);
    afe_rd_act = 1'b1;
    tick(1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n      = 1'b0;
    afe_clk    = 1'b0;
    afe_rd_act = 1'b0;
    pix_ready  = 1'b0;
    tick(3);
    checkOutput("rst_convst", 32'(adc_convst), 32'd0);
    checkOutput("rst_cs_n",   32'(adc_cs_n),   32'd1);
    checkOutput("rst_sclk",   32'(adc_sclk),   32'd1);
    checkOutput("rst_valid",  32'(pix_valid),  32'd0);
    checkOutput("rst_data",   32'(pix_data),   32'd0);
    checkOutput("rst_idx",    32'(pix_idx),    32'd0);
    checkOutput("rst_ldone",  32'(line_done),  32'd0);
    checkOutput("rst_ovr",    32'(overrun),    32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] single sample");
    afe_rd_act    = 1'b1;
    tick(1);
    convst_cycles = 0;
    sclk_rises    = 0;
    applyStimulus(16'hA5C3);
    waitValid("single");
    checkOutput("single_data",   32'(pix_data),    32'h0000A5C3);
    checkOutput("single_idx",    32'(pix_idx),     32'd0);
    checkOutput("single_convst", 32'(convst_cycles), 32'd40);
    checkOutput("single_sclk",   32'(sclk_rises),  32'd16);
    checkOutput("single_ovr",    32'(overrun),     32'd0);
    handshake();
    checkOutput("single_clear",  32'(pix_valid),   32'd0);

    $display("[TB] full line at minimum period");
    lineRestart();
    pix_ready = 1'b1;
    hs_q.delete();
    ld_count = 0;
    for (int k = 0; k < 64; k++) begin
      applyStimulus(16'(k * 257));
      tick(187);
    end
    tick(5);
    checkOutput("line_count", 32'(hs_q.size()), 32'd64);
    for (int k = 0; k < 64; k++)
      checkOutput($sformatf("line_%0d", k), 32'(hs_q[k]), 32'({6'(k), 16'(k * 257)}));
    checkOutput("line_done_cnt", 32'(ld_count), 32'd1);
    checkOutput("line_done_idx", 32'(ld_idx),   32'd63);
    checkOutput("line_ovr",      32'(overrun),  32'd0);
    pix_ready = 1'b0;

    $display("[TB] abort mid-shift");
    lineRestart();
    applyStimulus(16'h9999);
    tick(79);
    checkOutput("abort_pre_cs_n", 32'(adc_cs_n), 32'd0);
    checkOutput("abort_pre_sclk", 32'(adc_sclk), 32'd0);
    afe_rd_act = 1'b0;
    tick(1);
    checkOutput("abort_cs_n",   32'(adc_cs_n),   32'd1);
    checkOutput("abort_sclk",   32'(adc_sclk),   32'd1);
    checkOutput("abort_convst", 32'(adc_convst), 32'd0);
    tick(100);
    checkOutput("abort_valid",  32'(pix_valid),  32'd0);
    afe_rd_act = 1'b1;
    tick(1);
    applyStimulus(16'h0F0F);
    waitValid("after_abort");
    checkOutput("after_abort_idx",  32'(pix_idx),  32'd0);
    checkOutput("after_abort_data", 32'(pix_data), 32'h00000F0F);
    handshake();

    $display("[TB] backpressure");
    lineRestart();
    applyStimulus(16'h1111);
    tick(188);
    applyStimulus(16'h2222);
    tick(130);
    checkOutput("bp_valid", 32'(pix_valid), 32'd1);
    checkOutput("bp_data",  32'(pix_data),  32'h00001111);
    checkOutput("bp_idx",   32'(pix_idx),   32'd0);
    checkOutput("bp_ovr",   32'(overrun),   32'd1);
    handshake();
    checkOutput("bp_clear", 32'(pix_valid), 32'd0);
    applyStimulus(16'h3333);
    waitValid("bp_next");
    checkOutput("bp_next_idx",  32'(pix_idx),  32'd2);
    checkOutput("bp_next_data", 32'(pix_data), 32'h00003333);
    handshake();

    $display("[TB] edge while busy");
    doReset();
    checkOutput("busy_ovr_reset", 32'(overrun), 32'd0);
    afe_rd_act = 1'b1;
    pix_ready  = 1'b1;
    tick(1);
    hs_q.delete();
    applyStimulus(16'h1234);
    tick(6);
    applyStimulus(16'h1234);
    tick(250);
    checkOutput("busy_count", 32'(hs_q.size()), 32'd1);
    checkOutput("busy_word",  32'(hs_q[0]),     32'({6'd0, 16'h1234}));
    checkOutput("busy_ovr",   32'(overrun),     32'd1);
    pix_ready = 1'b0;

    $display("[TB] async reset mid-convst");
    applyStimulus(16'hFFFF);
    tick(30);
    checkOutput("ares_pre_convst", 32'(adc_convst), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ares_convst", 32'(adc_convst), 32'd0);
    checkOutput("ares_cs_n",   32'(adc_cs_n),   32'd1);
    checkOutput("ares_sclk",   32'(adc_sclk),   32'd1);
    checkOutput("ares_valid",  32'(pix_valid),  32'd0);
    checkOutput("ares_data",   32'(pix_data),   32'd0);
    checkOutput("ares_idx",    32'(pix_idx),    32'd0);
    checkOutput("ares_ovr",    32'(overrun),    32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
